// File: rtl/ex_alu_stage_if.sv
// ----------------------------------------------------------------------------
// ex_alu_stage_if
// Bundle between the decode/forwarding logic and the execute-stage ALU.
// The master side (decode) issues ops and receives results.
// The slave side is the ALU stage itself.
// ----------------------------------------------------------------------------
interface ex_alu_stage_if #(
    parameter int WIDTH = 32,
    parameter int RD_W  = 5
);
    // Issue side
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       opcode;
    logic [WIDTH-1:0] src_a;
    logic [WIDTH-1:0] src_b;
    logic [RD_W-1:0]  rd_in;
    logic             reg_write_in;

    // Completion side
    logic             out_valid;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic [RD_W-1:0]  rd_out;
    logic             reg_write_out;

    modport master (
        output flush,
        output in_valid,
        output opcode,
        output src_a,
        output src_b,
        output rd_in,
        output reg_write_in,
        input  in_ready,
        input  out_valid,
        input  result,
        input  zero,
        input  rd_out,
        input  reg_write_out
    );

    modport slave (
        input  flush,
        input  in_valid,
        input  opcode,
        input  src_a,
        input  src_b,
        input  rd_in,
        input  reg_write_in,
        output in_ready,
        output out_valid,
        output result,
        output zero,
        output rd_out,
        output reg_write_out
    );
endinterface

// File: rtl/ex_alu_stage.sv
// ----------------------------------------------------------------------------
// ex_alu_stage
// Execute-stage ALU. Single-cycle ops (add/sub/and/or/slt/sltu/sll) retire one
// cycle after accept and can be issued every cycle. Multiply is an iterative
// shift-add unit: it occupies the stage for exactly WIDTH cycles and holds
// in_ready low for that time. There is no early termination, so the latency
// stays deterministic.
// ----------------------------------------------------------------------------
module ex_alu_stage #(
    parameter int WIDTH = 32,
    parameter int RD_W  = 5
) (
    input  logic           clk,
    input  logic           rst,
    ex_alu_stage_if.slave  bus
);

    // ------------------------------------------------------------------------
    // Local constants
    // ------------------------------------------------------------------------
    localparam int SHAMT_W = $clog2(WIDTH);
    localparam int CNT_W   = $clog2(WIDTH + 1);

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_AND  = 3'b010;
    localparam logic [2:0] OP_OR   = 3'b011;
    localparam logic [2:0] OP_SLT  = 3'b100;
    localparam logic [2:0] OP_SLTU = 3'b101;
    localparam logic [2:0] OP_SLL  = 3'b110;
    localparam logic [2:0] OP_MUL  = 3'b111;

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH);

    localparam logic [WIDTH-1:0] DATA_ZERO = {WIDTH{1'b0}};
    localparam logic [RD_W-1:0]  RD_ZERO   = {RD_W{1'b0}};

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } state_t;

    // ------------------------------------------------------------------------
    // Helpers
    // ------------------------------------------------------------------------
    // The zero flag is derived from the exact value being loaded into result.
    function automatic logic is_zero(input logic [WIDTH-1:0] value);
        return (value == DATA_ZERO);
    endfunction

    // Zero-extend a single comparison bit to a full-width result.
    function automatic logic [WIDTH-1:0] bool_ext(input logic bit_in);
        return {{(WIDTH-1){1'b0}}, bit_in};
    endfunction

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    state_t            state_r;
    logic [WIDTH-1:0]  mcand_r;
    logic [WIDTH-1:0]  mplier_r;
    logic [WIDTH-1:0]  acc_r;
    logic [CNT_W-1:0]  cnt_r;
    logic [RD_W-1:0]   mul_rd_r;
    logic              mul_rw_r;

    logic              out_valid_r;
    logic [WIDTH-1:0]  result_r;
    logic              zero_r;
    logic [RD_W-1:0]   rd_out_r;
    logic              reg_write_out_r;

    // ------------------------------------------------------------------------
    // Combinational signals
    // ------------------------------------------------------------------------
    logic              in_ready_s;
    logic              accept_s;
    logic [WIDTH-1:0]  alu_res_s;
    logic [WIDTH-1:0]  acc_next_s;
    logic [CNT_W-1:0]  cnt_next_s;
    logic              mul_done_s;

    // The ready signal depends only on state and reset, never on in_valid,
    // so upstream sees no combinational loop through the handshake.
    assign in_ready_s = (state_r == ST_IDLE) & ~rst;
    assign accept_s   = bus.in_valid & in_ready_s & ~bus.flush;

    // Single-cycle ALU datapath; mul is handled by the iterative unit below.
    always_comb begin
        alu_res_s = DATA_ZERO;
        case (bus.opcode)
            OP_ADD:  alu_res_s = bus.src_a + bus.src_b;
            OP_SUB:  alu_res_s = bus.src_a - bus.src_b;
            OP_AND:  alu_res_s = bus.src_a & bus.src_b;
            OP_OR:   alu_res_s = bus.src_a | bus.src_b;
            OP_SLT:  alu_res_s = bool_ext($signed(bus.src_a) < $signed(bus.src_b));
            OP_SLTU: alu_res_s = bool_ext(bus.src_a < bus.src_b);
            OP_SLL:  alu_res_s = bus.src_a << bus.src_b[SHAMT_W-1:0];
            OP_MUL:  alu_res_s = DATA_ZERO;
            default: alu_res_s = DATA_ZERO;
        endcase
    end

    // One shift-add iteration: conditional add, then the counter step that
    // decides whether this edge is the last iteration.
    always_comb begin
        if (mplier_r[0]) begin
            acc_next_s = acc_r + mcand_r;
        end else begin
            acc_next_s = acc_r;
        end
        cnt_next_s = cnt_r + CNT_ONE;
        if (state_r == ST_MUL) begin
            mul_done_s = (cnt_next_s == CNT_LAST);
        end else begin
            mul_done_s = 1'b0;
        end
    end

    // Control FSM, multiplier datapath and registered EX/MEM outputs.
    // Priority is reset, then flush, then completion/accept.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r         <= ST_IDLE;
            mcand_r         <= DATA_ZERO;
            mplier_r        <= DATA_ZERO;
            acc_r           <= DATA_ZERO;
            cnt_r           <= CNT_ZERO;
            mul_rd_r        <= RD_ZERO;
            mul_rw_r        <= 1'b0;
            out_valid_r     <= 1'b0;
            result_r        <= DATA_ZERO;
            zero_r          <= 1'b0;
            rd_out_r        <= RD_ZERO;
            reg_write_out_r <= 1'b0;
        end else if (bus.flush) begin
            // Kill any in-flight multiply and suppress this cycle's output;
            // result/zero/rd_out keep their last retired values.
            state_r         <= ST_IDLE;
            cnt_r           <= CNT_ZERO;
            out_valid_r     <= 1'b0;
            reg_write_out_r <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (accept_s && (bus.opcode == OP_MUL)) begin
                        state_r         <= ST_MUL;
                        mcand_r         <= bus.src_a;
                        mplier_r        <= bus.src_b;
                        acc_r           <= DATA_ZERO;
                        cnt_r           <= CNT_ZERO;
                        mul_rd_r        <= bus.rd_in;
                        mul_rw_r        <= bus.reg_write_in;
                        out_valid_r     <= 1'b0;
                        reg_write_out_r <= 1'b0;
                    end else if (accept_s) begin
                        out_valid_r     <= 1'b1;
                        result_r        <= alu_res_s;
                        zero_r          <= is_zero(alu_res_s);
                        rd_out_r        <= bus.rd_in;
                        reg_write_out_r <= bus.reg_write_in;
                    end else begin
                        out_valid_r     <= 1'b0;
                        reg_write_out_r <= 1'b0;
                    end
                end
                ST_MUL: begin
                    acc_r    <= acc_next_s;
                    mcand_r  <= mcand_r << 1;
                    mplier_r <= mplier_r >> 1;
                    cnt_r    <= cnt_next_s;
                    if (mul_done_s) begin
                        // Final iteration: retire the product including this
                        // edge's partial add and reopen the stage.
                        state_r         <= ST_IDLE;
                        out_valid_r     <= 1'b1;
                        result_r        <= acc_next_s;
                        zero_r          <= is_zero(acc_next_s);
                        rd_out_r        <= mul_rd_r;
                        reg_write_out_r <= mul_rw_r;
                    end else begin
                        out_valid_r     <= 1'b0;
                        reg_write_out_r <= 1'b0;
                    end
                end
                default: begin
                    state_r         <= ST_IDLE;
                    cnt_r           <= CNT_ZERO;
                    out_valid_r     <= 1'b0;
                    reg_write_out_r <= 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Output drive
    // ------------------------------------------------------------------------
    assign bus.in_ready      = in_ready_s;
    assign bus.out_valid     = out_valid_r;
    assign bus.result        = result_r;
    assign bus.zero          = zero_r;
    assign bus.rd_out        = rd_out_r;
    assign bus.reg_write_out = reg_write_out_r;

endmodule

// File: tb/tb_ex_alu_stage.sv
// ----------------------------------------------------------------------------
// tb_ex_alu_stage
// Directed scenarios plus randomized traffic for the execute-stage ALU,
// checked against an arithmetic reference model of the ALU operations.
// ----------------------------------------------------------------------------
module tb_ex_alu_stage;

    localparam int W  = 32;
    localparam int RW = 5;

    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    // Free-running 10 ns clock.
    always #5 clk = ~clk;

    ex_alu_stage_if #(.WIDTH(W), .RD_W(RW)) bus ();

    ex_alu_stage #(.WIDTH(W), .RD_W(RW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Reference model: the ALU operations as plain arithmetic.
    function automatic logic [31:0] ref_alu(input logic [2:0] op,
                                            input logic [31:0] a,
                                            input logic [31:0] b);
        int sa;
        int sb;
        longint unsigned pa;
        longint unsigned pb;
        longint unsigned prod;
        sa = a;
        sb = b;
        pa = 64'(a);
        pb = 64'(b);
        prod = pa * pb;
        case (op)
            3'd0:    return a + b;
            3'd1:    return a - b;
            3'd2:    return a & b;
            3'd3:    return a | b;
            3'd4:    return (sa < sb) ? 32'd1 : 32'd0;
            3'd5:    return (a < b) ? 32'd1 : 32'd0;
            3'd6:    return a << (b % 32);
            default: return prod[31:0];
        endcase
    endfunction

    // Advance one clock and settle just after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, input logic rw);
        bus.in_valid     = 1'b1;
        bus.opcode       = op;
        bus.src_a        = a;
        bus.src_b        = b;
        bus.rd_in        = rd;
        bus.reg_write_in = rw;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.flush = 1'b0;
        bus.in_valid = 1'b0;
        issue(3'd0, 32'd0, 32'd0, 5'd0, 1'b0);
        bus.in_valid = 1'b0;
        step();
        step();
        checks++; if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL reset_in_ready got=%0b exp=0", bus.in_ready); end
        checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%0b exp=0", bus.out_valid); end
        checks++; if (bus.result !== 32'd0) begin failures++; $display("FAIL reset_result got=%h exp=0", bus.result); end
        checks++; if (bus.zero !== 1'b0) begin failures++; $display("FAIL reset_zero got=%0b exp=0", bus.zero); end
        checks++; if (bus.rd_out !== 5'd0) begin failures++; $display("FAIL reset_rd_out got=%0d exp=0", bus.rd_out); end
        checks++; if (bus.reg_write_out !== 1'b0) begin failures++; $display("FAIL reset_rw_out got=%0b exp=0", bus.reg_write_out); end
        rst = 1'b0;
        step();
        checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL reset_release_ready got=%0b exp=1", bus.in_ready); end
    endtask

    task automatic test_add();
        issue(3'd0, 32'd5, 32'd7, 5'd3, 1'b1);
        step();
        bus.in_valid = 1'b0;
        checks++; if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL add_valid got=%0b exp=1", bus.out_valid); end
        checks++; if (bus.result !== 32'd12) begin failures++; $display("FAIL add_result got=%0d exp=12", bus.result); end
        checks++; if (bus.zero !== 1'b0) begin failures++; $display("FAIL add_zero got=%0b exp=0", bus.zero); end
        checks++; if (bus.rd_out !== 5'd3) begin failures++; $display("FAIL add_rd got=%0d exp=3", bus.rd_out); end
        checks++; if (bus.reg_write_out !== 1'b1) begin failures++; $display("FAIL add_rw got=%0b exp=1", bus.reg_write_out); end
        step();
        checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL add_pulse got=%0b exp=0", bus.out_valid); end
        checks++; if (bus.result !== 32'd12) begin failures++; $display("FAIL add_hold got=%0d exp=12", bus.result); end
        checks++; if (bus.reg_write_out !== 1'b0) begin failures++; $display("FAIL add_rw_idle got=%0b exp=0", bus.reg_write_out); end
    endtask

    task automatic test_back_to_back();
        logic [2:0]  ops [4];
        logic [31:0] as  [4];
        logic [31:0] bs  [4];
        logic [31:0] exp;
        ops[0] = 3'd1; as[0] = 32'd3;          bs[0] = 32'd3;
        ops[1] = 3'd4; as[1] = 32'hFFFF_FFFF;  bs[1] = 32'd1;
        ops[2] = 3'd5; as[2] = 32'hFFFF_FFFF;  bs[2] = 32'd1;
        ops[3] = 3'd6; as[3] = 32'd1;          bs[3] = 32'h3F;
        for (int i = 0; i < 4; i++) begin
            issue(ops[i], as[i], bs[i], 5'(i + 10), 1'b1);
            checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL b2b_ready[%0d] got=%0b exp=1", i, bus.in_ready); end
            step();
            exp = ref_alu(ops[i], as[i], bs[i]);
            checks++; if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL b2b_valid[%0d] got=%0b exp=1", i, bus.out_valid); end
            checks++; if (bus.result !== exp) begin failures++; $display("FAIL b2b_result[%0d] got=%h exp=%h", i, bus.result, exp); end
            checks++; if (bus.zero !== (exp == 32'd0)) begin failures++; $display("FAIL b2b_zero[%0d] got=%0b exp=%0b", i, bus.zero, exp == 32'd0); end
            checks++; if (bus.rd_out !== 5'(i + 10)) begin failures++; $display("FAIL b2b_rd[%0d] got=%0d exp=%0d", i, bus.rd_out, i + 10); end
        end
        bus.in_valid = 1'b0;
        checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL b2b_ready_end got=%0b exp=1", bus.in_ready); end
    endtask

    task automatic test_mul_basic();
        int cyc;
        int busy_ready;
        issue(3'd7, 32'h0000_FFFF, 32'h0001_0001, 5'd21, 1'b1);
        step();
        // Hold a following add on the bus the whole time.
        issue(3'd0, 32'd2, 32'd3, 5'd7, 1'b1);
        cyc = 0;
        busy_ready = 0;
        while (bus.out_valid !== 1'b1 && cyc < 40) begin
            if (bus.in_ready !== 1'b0) busy_ready++;
            step();
            cyc++;
        end
        checks++; if (cyc !== 32) begin failures++; $display("FAIL mul_latency got=%0d exp=32", cyc); end
        checks++; if (busy_ready !== 0) begin failures++; $display("FAIL mul_busy_ready got=%0d exp=0", busy_ready); end
        checks++; if (bus.result !== 32'hFFFF_FFFF) begin failures++; $display("FAIL mul_result got=%h exp=ffffffff", bus.result); end
        checks++; if (bus.rd_out !== 5'd21) begin failures++; $display("FAIL mul_rd got=%0d exp=21", bus.rd_out); end
        checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL mul_done_ready got=%0b exp=1", bus.in_ready); end
        step();
        bus.in_valid = 1'b0;
        checks++; if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL mul_follow_valid got=%0b exp=1", bus.out_valid); end
        checks++; if (bus.result !== 32'd5) begin failures++; $display("FAIL mul_follow_result got=%0d exp=5", bus.result); end
        checks++; if (bus.rd_out !== 5'd7) begin failures++; $display("FAIL mul_follow_rd got=%0d exp=7", bus.rd_out); end
        step();
    endtask

    task automatic test_mul_table();
        logic [31:0] as [8];
        logic [31:0] bs [8];
        logic [31:0] exp;
        int cyc;
        int busy_ready;
        as[0] = 32'h8000_0000; bs[0] = 32'd2;
        as[1] = 32'd7;         bs[1] = 32'd0;
        as[2] = 32'hFFFF_FFFF; bs[2] = 32'hFFFF_FFFF;
        for (int i = 3; i < 8; i++) begin
            as[i] = $urandom;
            bs[i] = $urandom;
        end
        for (int i = 0; i < 8; i++) begin
            issue(3'd7, as[i], bs[i], 5'(i + 1), i[0]);
            step();
            bus.in_valid = 1'b0;
            exp = ref_alu(3'd7, as[i], bs[i]);
            cyc = 0;
            busy_ready = 0;
            while (bus.out_valid !== 1'b1 && cyc < 40) begin
                if (bus.in_ready !== 1'b0) busy_ready++;
                step();
                cyc++;
            end
            checks++; if (cyc !== 32) begin failures++; $display("FAIL mult_latency[%0d] got=%0d exp=32", i, cyc); end
            checks++; if (busy_ready !== 0) begin failures++; $display("FAIL mult_busy[%0d] got=%0d exp=0", i, busy_ready); end
            checks++; if (bus.result !== exp) begin failures++; $display("FAIL mult_result[%0d] got=%h exp=%h", i, bus.result, exp); end
            checks++; if (bus.zero !== (exp == 32'd0)) begin failures++; $display("FAIL mult_zero[%0d] got=%0b exp=%0b", i, bus.zero, exp == 32'd0); end
            checks++; if (bus.rd_out !== 5'(i + 1)) begin failures++; $display("FAIL mult_rd[%0d] got=%0d exp=%0d", i, bus.rd_out, i + 1); end
            checks++; if (bus.reg_write_out !== i[0]) begin failures++; $display("FAIL mult_rw[%0d] got=%0b exp=%0b", i, bus.reg_write_out, i[0]); end
        end
        step();
    endtask

    task automatic test_flush();
        int spurious;
        issue(3'd7, 32'd3, 32'd4, 5'd9, 1'b1);
        step();
        bus.in_valid = 1'b0;
        for (int i = 0; i < 9; i++) step();
        bus.flush = 1'b1;
        step();
        bus.flush = 1'b0;
        checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL flush_valid got=%0b exp=0", bus.out_valid); end
        checks++; if (bus.reg_write_out !== 1'b0) begin failures++; $display("FAIL flush_rw got=%0b exp=0", bus.reg_write_out); end
        checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL flush_ready got=%0b exp=1", bus.in_ready); end
        spurious = 0;
        for (int i = 0; i < 40; i++) begin
            if (bus.out_valid !== 1'b0) spurious++;
            step();
        end
        checks++; if (spurious !== 0) begin failures++; $display("FAIL flush_stale got=%0d exp=0", spurious); end
        issue(3'd0, 32'd1, 32'd1, 5'd4, 1'b1);
        step();
        bus.in_valid = 1'b0;
        checks++; if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL flush_add_valid got=%0b exp=1", bus.out_valid); end
        checks++; if (bus.result !== 32'd2) begin failures++; $display("FAIL flush_add_result got=%0d exp=2", bus.result); end
    endtask

    task automatic test_rst_mid_mul();
        int spurious;
        issue(3'd7, 32'h0000_FFFF, 32'd3, 5'd9, 1'b1);
        step();
        bus.in_valid = 1'b0;
        for (int i = 0; i < 4; i++) step();
        rst = 1'b1;
        step();
        checks++; if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL rstm_ready got=%0b exp=0", bus.in_ready); end
        checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL rstm_valid got=%0b exp=0", bus.out_valid); end
        checks++; if (bus.result !== 32'd0) begin failures++; $display("FAIL rstm_result got=%h exp=0", bus.result); end
        checks++; if (bus.zero !== 1'b0) begin failures++; $display("FAIL rstm_zero got=%0b exp=0", bus.zero); end
        checks++; if (bus.rd_out !== 5'd0) begin failures++; $display("FAIL rstm_rd got=%0d exp=0", bus.rd_out); end
        checks++; if (bus.reg_write_out !== 1'b0) begin failures++; $display("FAIL rstm_rw got=%0b exp=0", bus.reg_write_out); end
        rst = 1'b0;
        step();
        checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL rstm_release got=%0b exp=1", bus.in_ready); end
        spurious = 0;
        for (int i = 0; i < 40; i++) begin
            if (bus.out_valid !== 1'b0 || bus.result !== 32'd0) spurious++;
            step();
        end
        checks++; if (spurious !== 0) begin failures++; $display("FAIL rstm_stale got=%0d exp=0", spurious); end
    endtask

    task automatic test_random();
        logic [31:0] exp_res;
        logic [4:0]  exp_rd;
        logic        exp_rw;
        logic        v, f, acc, rw;
        logic [2:0]  op;
        logic [31:0] a, b;
        logic [4:0]  rd;
        exp_res = 32'd0;
        exp_rd  = 5'd0;
        exp_rw  = 1'b0;
        for (int i = 0; i < 300; i++) begin
            v  = (i == 0) ? 1'b1 : (($urandom % 4) != 0);
            f  = (i != 0) && (($urandom % 10) == 0);
            op = 3'($urandom % 7);
            a  = $urandom;
            b  = (($urandom % 4) == 0) ? a : $urandom;
            if (($urandom % 8) == 0) begin
                a = $urandom % 4;
                b = $urandom % 4;
            end
            rd = 5'($urandom);
            rw = 1'($urandom);
            issue(op, a, b, rd, rw);
            bus.in_valid = v;
            bus.flush    = f;
            step();
            acc = v & ~f;
            if (acc) begin
                exp_res = ref_alu(op, a, b);
                exp_rd  = rd;
                exp_rw  = rw;
            end
            checks++; if (bus.out_valid !== acc) begin failures++; $display("FAIL rnd_valid[%0d] got=%0b exp=%0b", i, bus.out_valid, acc); end
            checks++; if (bus.result !== exp_res) begin failures++; $display("FAIL rnd_result[%0d] op=%0d got=%h exp=%h", i, op, bus.result, exp_res); end
            checks++; if (bus.zero !== (exp_res == 32'd0)) begin failures++; $display("FAIL rnd_zero[%0d] got=%0b exp=%0b", i, bus.zero, exp_res == 32'd0); end
            checks++; if (bus.rd_out !== exp_rd) begin failures++; $display("FAIL rnd_rd[%0d] got=%0d exp=%0d", i, bus.rd_out, exp_rd); end
            checks++; if (bus.reg_write_out !== (acc & exp_rw)) begin failures++; $display("FAIL rnd_rw[%0d] got=%0b exp=%0b", i, bus.reg_write_out, acc & exp_rw); end
            checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL rnd_ready[%0d] got=%0b exp=1", i, bus.in_ready); end
        end
        bus.in_valid = 1'b0;
        bus.flush    = 1'b0;
        step();
    endtask

    // Scenario sequence and summary.
    initial begin
        test_reset();
        test_add();
        test_back_to_back();
        test_mul_basic();
        test_mul_table();
        test_flush();
        test_rst_mid_mul();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global time bound so the run always ends.
    initial begin
        #2000000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
